// File: rtl/counter_cmd_gen_pkg.sv
// Shared encodings and default timing for the counter command front-end.
package counter_cmd_gen_pkg;

  localparam int VAL_W          = 5;
  localparam int DEF_DEB_CYCLES = 16;
  localparam int DEF_REP_DELAY  = 64;
  localparam int DEF_REP_PERIOD = 16;
  localparam int DEF_TMR_W      = 8;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_LOAD = 2'd1,
    CMD_UP   = 2'd2,
    CMD_DOWN = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_WAIT   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

endpackage

// File: rtl/btn_conditioner.sv
// Raw button -> 2-flop sync -> debounced level, plus a one-cycle rise flag.
module btn_conditioner #(
  parameter int DEB_CYCLES = 16,
  parameter int TMR_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic [1:0]       sync;
  logic [TMR_W-1:0] cnt;
  logic             level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync    <= {sync[0], raw};
      level_d <= level;
      // Any sample agreeing with the current level restarts the stability count.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == TMR_W'(DEB_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/counter_cmd_gen.sv
// Turns bouncy Load/Up/Down buttons and SW into clean single-cycle counter commands.
module counter_cmd_gen
  import counter_cmd_gen_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int REP_DELAY  = DEF_REP_DELAY,
  parameter int REP_PERIOD = DEF_REP_PERIOD,
  parameter int TMR_W      = DEF_TMR_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN_LOAD,
  input  logic             BTN_UP,
  input  logic             BTN_DOWN,
  input  logic [VAL_W-1:0] SW,
  input  logic             High,
  input  logic             Low,
  output logic [VAL_W-1:0] IN,
  output logic             Load,
  output logic             Up,
  output logic             Down
);

  // Button index: 0 = load, 1 = up, 2 = down.
  logic [2:0] raw, lvl, rise;
  assign raw = {BTN_DOWN, BTN_UP, BTN_LOAD};

  for (genvar b = 0; b < 3; b++) begin : g_btn
    btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .TMR_W(TMR_W)) u_btn (
      .clk  (CLK),
      .rst_n(RST),
      .raw  (raw[b]),
      .level(lvl[b]),
      .rise (rise[b])
    );
  end

  logic [VAL_W-1:0] sw_s1, sw_s2;

  // Repeat FSMs: index 0 = up, 1 = down.
  rpt_state_t       state     [2];
  rpt_state_t       state_nxt [2];
  logic [TMR_W-1:0] tmr       [2];
  logic [TMR_W-1:0] tmr_nxt   [2];
  logic [1:0]       req;
  cmd_t             cmd;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_nxt[i] = state[i];
      tmr_nxt[i]   = tmr[i];
      req[i]       = 1'b0;
      if (!lvl[i+1]) begin
        state_nxt[i] = RPT_IDLE;
        tmr_nxt[i]   = '0;
      end else begin
        case (state[i])
          RPT_IDLE: if (rise[i+1]) begin
            req[i]       = 1'b1;
            state_nxt[i] = RPT_WAIT;
            tmr_nxt[i]   = '0;
          end
          RPT_WAIT: if (tmr[i] == TMR_W'(REP_DELAY - 1)) begin
            req[i]       = 1'b1;
            state_nxt[i] = RPT_REPEAT;
            tmr_nxt[i]   = '0;
          end else begin
            tmr_nxt[i] = tmr[i] + 1'b1;
          end
          RPT_REPEAT: if (tmr[i] == TMR_W'(REP_PERIOD - 1)) begin
            req[i]     = 1'b1;
            tmr_nxt[i] = '0;
          end else begin
            tmr_nxt[i] = tmr[i] + 1'b1;
          end
          default: begin
            state_nxt[i] = RPT_IDLE;
            tmr_nxt[i]   = '0;
          end
        endcase
      end
    end
  end

  // Saturated directions drop their request; fixed priority Load > Down > Up.
  always_comb begin
    cmd = CMD_NONE;
    if (rise[0] && lvl[0])    cmd = CMD_LOAD;
    else if (req[1] && !Low)  cmd = CMD_DOWN;
    else if (req[0] && !High) cmd = CMD_UP;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= RPT_IDLE;
        tmr[i]   <= '0;
      end
      sw_s1 <= '0;
      sw_s2 <= '0;
      IN    <= '0;
      Load  <= 1'b0;
      Up    <= 1'b0;
      Down  <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= state_nxt[i];
        tmr[i]   <= tmr_nxt[i];
      end
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
      Load  <= (cmd == CMD_LOAD);
      Up    <= (cmd == CMD_UP);
      Down  <= (cmd == CMD_DOWN);
      if (cmd == CMD_LOAD) IN <= sw_s2;
    end
  end

endmodule

// File: tb/tb_counter_cmd_gen.sv
// Directed bench for counter_cmd_gen: pulse timing, repeat, masking, arbitration, reset.
module tb_counter_cmd_gen;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BTN_LOAD, BTN_UP, BTN_DOWN;
  logic [4:0] SW;
  logic       High, Low;
  logic [4:0] IN;
  logic       Load, Up, Down;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int up_q[$], dn_q[$], ld_q[$];
  int none[$];
  int e[$];
  logic [4:0] in_at_load = '0;

  counter_cmd_gen #(
    .DEB_CYCLES(4), .REP_DELAY(8), .REP_PERIOD(3), .TMR_W(8)
  ) dut (
    .CLK(CLK), .RST(RST),
    .BTN_LOAD(BTN_LOAD), .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN),
    .SW(SW), .High(High), .Low(Low),
    .IN(IN), .Load(Load), .Up(Up), .Down(Down)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_list(input string tag, input int got[$], input int exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(tag, got[i], exp[i]);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clear_q();
    up_q.delete(); dn_q.delete(); ld_q.delete();
  endtask

  // cyc holds the index of the most recent rising edge; a pulse is logged with
  // the edge that registered it.
  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    #2;
    if (Up)   up_q.push_back(cyc);
    if (Down) dn_q.push_back(cyc);
    if (Load) begin
      ld_q.push_back(cyc);
      in_at_load = IN;
    end
    chk("onehot", ($countones({Load, Up, Down}) <= 1) ? 1 : 0, 1);
  end

  initial begin
    int c, p0, r, d;
    RST = 1'b0; BTN_LOAD = 0; BTN_UP = 0; BTN_DOWN = 0;
    SW = 5'd0; High = 0; Low = 0;
    step(3);
    chk("rst_load", int'(Load), 0);
    chk("rst_up",   int'(Up),   0);
    chk("rst_down", int'(Down), 0);
    chk("rst_in",   int'(IN),   0);
    RST = 1'b1;
    step(3);

    // Clean Up press, released before the first repeat slot.
    clear_q(); c = cyc;
    BTN_UP = 1; step(6); BTN_UP = 0; step(20);
    e = {c + 7};
    chk_list("t1_up", up_q, e);
    chk_list("t1_down", dn_q, none);
    chk_list("t1_load", ld_q, none);

    // Bouncing Up (2 high / 2 low) then stable high.
    clear_q(); c = cyc;
    for (int k = 0; k < 20; k++) begin
      BTN_UP = ((k / 2) % 2 == 0);
      step(1);
    end
    BTN_UP = 1; step(6); BTN_UP = 0; step(20);
    e = {c + 27};
    chk_list("t2_up", up_q, e);

    // Down hold with repeat; Low masks the middle slots, no catch-up on release.
    clear_q(); c = cyc; p0 = c + 7;
    BTN_DOWN = 1; step(19);
    Low = 1; step(9);
    Low = 0; step(3);
    BTN_DOWN = 0; step(20);
    e = {p0, p0 + 8, p0 + 11, p0 + 23, p0 + 26, p0 + 29};
    chk_list("t3_down", dn_q, e);
    chk_list("t3_up", up_q, none);

    // Load and Up debounce together: Load wins, IN captures SW, no Load repeat.
    SW = 5'b10110; step(3);
    clear_q(); c = cyc;
    BTN_LOAD = 1; BTN_UP = 1; step(12);
    BTN_LOAD = 0; BTN_UP = 0; step(20);
    e = {c + 7};
    chk_list("t4_load", ld_q, e);
    chk("t4_in", int'(in_at_load), 22);
    e = {c + 15, c + 18};
    chk_list("t4_up", up_q, e);
    chk_list("t4_down", dn_q, none);

    // High blocks Up entirely; Down still goes through.
    High = 1;
    clear_q();
    BTN_UP = 1; step(20); BTN_UP = 0; step(12);
    chk_list("t5_up", up_q, none);
    d = cyc;
    BTN_DOWN = 1; step(6); BTN_DOWN = 0; step(12);
    e = {d + 7};
    chk_list("t5_down", dn_q, e);
    High = 0;

    // Reset during REPEAT with Down held, then a fresh press schedule.
    clear_q(); c = cyc; p0 = c + 7;
    BTN_DOWN = 1; step(18);
    chk("t6_pre_down", int'(Down), 1);
    RST = 1'b0; #1;
    chk("t6_rst_down", int'(Down), 0);
    chk("t6_rst_up",   int'(Up),   0);
    chk("t6_rst_load", int'(Load), 0);
    chk("t6_rst_in",   int'(IN),   0);
    step(1);
    RST = 1'b1; clear_q(); r = cyc;
    step(12); BTN_DOWN = 0; step(20);
    e = {r + 7, r + 15, r + 18};
    chk_list("t6_down", dn_q, e);
    chk_list("t6_up", up_q, none);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
